// File: rtl/dbg_core_unit.sv
// Debug control unit: register-mapped halt/step control, breakpoint hit capture,
// PC snapshot, new-PC injection and a free-running cycle counter gated by halt.
module dbg_core_unit (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic [15:0] dbg_addr_i,
    input  logic [31:0] dbg_data_i,
    output logic [31:0] dbg_data_o,
    input  logic        dbg_stb_i,
    input  logic        dbg_we_i,
    output logic        dbg_ack_o,
    input  logic        dbg_stall_i,
    output logic        dbg_bp_o,
    input  logic        core_trap_i,
    input  logic        core_retire_i,
    input  logic [31:0] core_pc_i,
    output logic        core_halt_o,
    output logic [31:0] core_npc_o,
    output logic        core_npc_we_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] addr_r;
    logic        we_r;
    logic [31:0] wdata_r;

    logic        ctrl_halt_r;
    logic        ctrl_sste_r;
    logic        hit_bp_r;
    logic        hit_ss_r;
    logic [31:0] ppc_r;
    logic [31:0] cycle_r;
    logic [31:0] npc_r;
    logic        npc_we_r;

    logic        halt_s;
    logic        set_bp_s;
    logic        set_ss_s;
    logic        wr_en_s;
    logic        wr_ctrl_s;
    logic        wr_hit_s;
    logic        wr_npc_s;
    logic        wr_cycle_s;
    logic [31:0] rdata_s;

    assign halt_s     = ctrl_halt_r | dbg_stall_i | hit_bp_r | hit_ss_r;
    assign set_bp_s   = core_trap_i & ~halt_s;
    assign set_ss_s   = core_retire_i & ~halt_s & ctrl_sste_r;
    assign wr_en_s    = (state_r == ST_ACK) & we_r;
    assign wr_ctrl_s  = wr_en_s & (addr_r == 16'h0000);
    assign wr_hit_s   = wr_en_s & (addr_r == 16'h0001);
    assign wr_npc_s   = wr_en_s & (addr_r == 16'h0003);
    assign wr_cycle_s = wr_en_s & (addr_r == 16'h0004);

    assign core_halt_o   = halt_s;
    assign dbg_bp_o      = hit_bp_r | hit_ss_r;
    assign dbg_ack_o     = (state_r == ST_ACK);
    assign dbg_data_o    = (state_r == ST_ACK) ? rdata_s : 32'd0;
    assign core_npc_o    = npc_r;
    assign core_npc_we_o = npc_we_r;

    // Read mux; addr_r is stable through ACK so data reflects state at ACK start
    always_comb begin
        rdata_s = 32'd0;
        case (addr_r)
            16'h0000: rdata_s = {30'd0, ctrl_sste_r, ctrl_halt_r};
            16'h0001: rdata_s = {30'd0, hit_ss_r, hit_bp_r};
            16'h0002: rdata_s = ppc_r;
            16'h0004: rdata_s = cycle_r;
            default:  rdata_s = 32'd0;
        endcase
    end

    // Access handshake FSM; request fields captured when the strobe is accepted
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state_r <= ST_IDLE;
            addr_r  <= 16'd0;
            we_r    <= 1'b0;
            wdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dbg_stb_i) begin
                        state_r <= ST_ACK;
                        addr_r  <= dbg_addr_i;
                        we_r    <= dbg_we_i;
                        wdata_r <= dbg_data_i;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACK: state_r <= ST_WAIT_LOW;
                ST_WAIT_LOW: begin
                    if (!dbg_stb_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_LOW;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Debug registers; hit sets beat W1C clears, counter clear beats increment
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            ctrl_halt_r <= 1'b0;
            ctrl_sste_r <= 1'b0;
            hit_bp_r    <= 1'b0;
            hit_ss_r    <= 1'b0;
            ppc_r       <= 32'd0;
            cycle_r     <= 32'd0;
            npc_r       <= 32'd0;
            npc_we_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_halt_r <= wdata_r[0];
                ctrl_sste_r <= wdata_r[1];
            end
            hit_bp_r <= set_bp_s | (hit_bp_r & ~(wr_hit_s & wdata_r[0]));
            hit_ss_r <= set_ss_s | (hit_ss_r & ~(wr_hit_s & wdata_r[1]));
            if (set_bp_s | set_ss_s) begin
                ppc_r <= core_pc_i;
            end
            if (wr_cycle_s) begin
                cycle_r <= 32'd0;
            end else if (!halt_s) begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (wr_npc_s) begin
                npc_r <= wdata_r;
            end
            npc_we_r <= wr_npc_s;
        end
    end

endmodule

// File: tb/tb_dbg_core_unit.sv
// Bench for dbg_core_unit: directed scenarios then randomized traffic, checked
// against a cycle-level behavioural model through an ack scoreboard.
module tb_dbg_core_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] dbg_data_o;
    logic        dbg_ack_o;
    logic        dbg_bp_o;
    logic        core_halt_o;
    logic [31:0] core_npc_o;
    logic        core_npc_we_o;

    always #5 clk = ~clk;

    dbg_core_unit dut (
        .cpu_clk_i     (clk),
        .cpu_rst_i     (rst),
        .dbg_addr_i    (addr),
        .dbg_data_i    (wdata),
        .dbg_data_o    (dbg_data_o),
        .dbg_stb_i     (stb),
        .dbg_we_i      (we),
        .dbg_ack_o     (dbg_ack_o),
        .dbg_stall_i   (stall),
        .dbg_bp_o      (dbg_bp_o),
        .core_trap_i   (trap),
        .core_retire_i (retire),
        .core_pc_i     (pc),
        .core_halt_o   (core_halt_o),
        .core_npc_o    (core_npc_o),
        .core_npc_we_o (core_npc_we_o)
    );

    typedef struct {
        logic [31:0] data;
        int          stamp;
    } exp_t;

    exp_t exp_q[$];

    // Architectural model state
    logic        m_halt = 1'b0, m_sste = 1'b0, m_bp = 1'b0, m_ss = 1'b0;
    logic [31:0] m_ppc = 32'd0, m_npc = 32'd0, m_cycle = 32'd0;
    logic        m_npc_we = 1'b0;
    logic        m_in_ack = 1'b0, m_wait_low = 1'b0;
    logic [15:0] m_addr = 16'd0;
    logic        m_we = 1'b0;
    logic [31:0] m_data = 32'd0;
    int          cyc = 0;

    bit          preload = 1'b0;
    bit          rand_mode = 1'b0;
    bit          finish_req = 1'b0;
    int          timeouts = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a)
            16'd0:   return {30'd0, m_sste, m_halt};
            16'd1:   return {30'd0, m_ss, m_bp};
            16'd2:   return m_ppc;
            16'd4:   return m_cycle;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: applies the register rules once per rising edge
    always @(posedge clk) begin
        logic h, wr, set_bp, set_ss, nbp, nss;
        logic [31:0] base;
        cyc = cyc + 1;
        if (rst) begin
            m_halt = 1'b0; m_sste = 1'b0; m_bp = 1'b0; m_ss = 1'b0;
            m_ppc = 32'd0; m_npc = 32'd0; m_cycle = 32'd0; m_npc_we = 1'b0;
            m_in_ack = 1'b0; m_wait_low = 1'b0;
        end else begin
            h      = m_halt | stall | m_bp | m_ss;
            wr     = m_in_ack && m_we;
            base   = preload ? 32'hFFFF_FFFF : m_cycle;
            set_bp = trap && !h;
            set_ss = retire && !h && m_sste;
            nbp    = set_bp || (m_bp && !(wr && m_addr == 16'd1 && m_data[0]));
            nss    = set_ss || (m_ss && !(wr && m_addr == 16'd1 && m_data[1]));
            if (set_bp || set_ss) m_ppc = pc;
            if (wr && m_addr == 16'd0) begin
                m_halt = m_data[0];
                m_sste = m_data[1];
            end
            m_bp = nbp;
            m_ss = nss;
            m_npc_we = wr && m_addr == 16'd3;
            if (m_npc_we) m_npc = m_data;
            if (wr && m_addr == 16'd4) m_cycle = 32'd0;
            else if (h) m_cycle = base;
            else m_cycle = base + 32'd1;
            if (m_in_ack) begin
                m_in_ack = 1'b0;
                m_wait_low = 1'b1;
            end else if (m_wait_low) begin
                if (!stb) m_wait_low = 1'b0;
            end else if (stb) begin
                m_in_ack = 1'b1;
                m_addr = addr;
                m_we = we;
                m_data = wdata;
                exp_q.push_back('{model_read(addr), cyc});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: per-cycle output checks and ack scoreboard
    always @(negedge clk) begin
        exp_t e;
        chk("core_halt", {31'd0, core_halt_o}, {31'd0, m_halt | stall | m_bp | m_ss});
        chk("dbg_bp", {31'd0, dbg_bp_o}, {31'd0, m_bp | m_ss});
        chk("npc_we", {31'd0, core_npc_we_o}, {31'd0, m_npc_we});
        chk("npc", core_npc_o, m_npc);
        if (dbg_ack_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.stamp));
                chk("rdata", dbg_data_o, e.data);
            end
        end else begin
            chk("idle_data", dbg_data_o, 32'd0);
        end
        if (finish_req) begin
            chk("pending_acks", 32'(exp_q.size()), 32'd0);
            chk("ack_timeouts", 32'(timeouts), 32'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            trap   = ($urandom_range(0, 7) == 0);
            retire = ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 15) == 0);
            pc     = $urandom;
        end
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (dbg_ack_o) got = 1'b1;
        end
        if (!got) timeouts++;
    endtask

    task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input int hold, input bit trap_on_ack);
        addr = a; we = w; wdata = d; stb = 1'b1;
        wait_ack();
        if (trap_on_ack) trap = 1'b1;
        tick();
        trap = 1'b0;
        repeat (hold) tick();
        stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic t, input logic r, input logic [31:0] p);
        trap = t; retire = r; pc = p;
        tick();
        trap = 1'b0; retire = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // halt via CTRL, cycle frozen
        access(16'd0, 1'b1, 32'h1, 0, 1'b0);
        access(16'd0, 1'b0, 32'h0, 2, 1'b0);
        access(16'd4, 1'b0, 32'h0, 0, 1'b0);
        repeat (3) tick();
        access(16'd4, 1'b0, 32'h0, 0, 1'b0);
        // breakpoint trap and W1C
        access(16'd0, 1'b1, 32'h0, 0, 1'b0);
        pulse(1'b1, 1'b0, 32'h1C00_0080);
        tick();
        access(16'd1, 1'b0, 32'h0, 0, 1'b0);
        access(16'd2, 1'b0, 32'h0, 0, 1'b0);
        access(16'd1, 1'b1, 32'h1, 0, 1'b0);
        // set wins over same-cycle clear
        access(16'd1, 1'b1, 32'h1, 0, 1'b1);
        access(16'd1, 1'b0, 32'h0, 0, 1'b0);
        access(16'd1, 1'b1, 32'h3, 0, 1'b0);
        // single step plus trap together, then retire while halted
        access(16'd0, 1'b1, 32'h2, 0, 1'b0);
        pulse(1'b1, 1'b1, 32'h0000_0100);
        pulse(1'b0, 1'b1, 32'h0000_0200);
        access(16'd1, 1'b0, 32'h0, 0, 1'b0);
        access(16'd2, 1'b0, 32'h0, 0, 1'b0);
        access(16'd1, 1'b1, 32'h3, 0, 1'b0);
        access(16'd0, 1'b1, 32'h0, 0, 1'b0);
        // new PC injection
        access(16'd3, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        access(16'd3, 1'b0, 32'h0, 0, 1'b0);
        // cycle wrap and write-wins-over-increment
        force dut.cycle_r = 32'hFFFF_FFFF;
        preload = 1'b1;
        #2;
        release dut.cycle_r;
        tick();
        preload = 1'b0;
        access(16'd4, 1'b0, 32'h0, 0, 1'b0);
        access(16'd4, 1'b1, 32'h1234_5678, 0, 1'b0);
        access(16'd4, 1'b0, 32'h0, 0, 1'b0);
        // unmapped
        access(16'h0100, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        access(16'hFFFF, 1'b0, 32'h0, 1, 1'b0);
        // reset during ACK of a CTRL write, strobe held across release
        addr = 16'd0; we = 1'b1; wdata = 32'h1; stb = 1'b1;
        wait_ack();
        rst = 1'b1; we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wait_ack();
        tick();
        stb = 1'b0;
        tick();
        // randomized traffic
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: a = 16'd0;
                1: a = 16'd1;
                2: a = 16'd2;
                3: a = 16'd3;
                4: a = 16'd4;
                default: a = 16'($urandom_range(5, 16'hFFFF));
            endcase
            d = $urandom;
            if (a == 16'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            access(a, 1'($urandom_range(0, 1)), d, $urandom_range(0, 2), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_mode = 1'b0;
        trap = 1'b0; retire = 1'b0; stall = 1'b0;
        repeat (3) tick();
        finish_req = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor_stopped: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/dbg_core_unit.md
DBG_CORE_UNIT -- requirements
Module: dbg_core_unit

Interface
REQ-001 The block SHALL run on one clock, cpu_clk_i, with a synchronous, active-high reset, cpu_rst_i; all state SHALL update on the rising edge of cpu_clk_i only.
REQ-002 cpu_clk_i  input  1  block clock.
REQ-003 cpu_rst_i  input  1  synchronous active-high reset.
REQ-004 dbg_addr_i  input  16  debug register word address, sampled with dbg_stb_i.
REQ-005 dbg_data_i  input  32  debug write data.
REQ-006 dbg_data_o  output  32  debug read data, valid only while dbg_ack_o=1, 0 otherwise.
REQ-007 dbg_stb_i  input  1  access strobe, held high until acked.
REQ-008 dbg_we_i  input  1  1=write, 0=read, sampled with dbg_stb_i.
REQ-009 dbg_ack_o  output  1  single-cycle access acknowledge.
REQ-010 dbg_stall_i  input  1  external stall request from the debug module.
REQ-011 dbg_bp_o  output  1  breakpoint/step hit indication (OR of HIT bits).
REQ-012 core_trap_i  input  1  single-cycle breakpoint trap pulse from the core.
REQ-013 core_retire_i  input  1  single-cycle instruction-retired pulse.
REQ-014 core_pc_i  input  32  PC of the trapping/retiring instruction.
REQ-015 core_halt_o  output  1  halt request to the core.
REQ-016 core_npc_o  output  32  new PC value.
REQ-017 core_npc_we_o  output  1  single-cycle new-PC load strobe.

Function
REQ-018 Register map (word addresses): 0x0000 CTRL (bit0 HALT rw, bit1 SSTE rw, bits 31:2 read 0); 0x0001 HIT (bit0 BP, bit1 SS, write-1-to-clear); 0x0002 PPC (read-only); 0x0003 NPC (write-only, reads 0); 0x0004 CYCLE (read; any write clears to 0).
REQ-019 Unmapped addresses SHALL read 0, ignore writes, and still be acked.
REQ-020 Access FSM states: IDLE, ACK, WAIT_LOW. IDLE with dbg_stb_i=1 -> ACK. ACK -> WAIT_LOW unconditionally. WAIT_LOW with dbg_stb_i=0 -> IDLE.
REQ-021 dbg_ack_o SHALL be 1 exactly in the ACK state, giving one cycle of latency from the strobe being sampled to ack; a strobe held high past ack SHALL NOT start a second access.
REQ-022 Writes SHALL take effect at the end of the ACK cycle; read data SHALL reflect register state at the start of the ACK cycle.
REQ-023 An NPC write SHALL drive core_npc_o = written value and pulse core_npc_we_o for exactly the cycle after ACK; core_npc_o SHALL hold its value until the next NPC write.
REQ-024 core_halt_o SHALL equal CTRL.HALT | dbg_stall_i | HIT.BP | HIT.SS, combinationally.
REQ-025 core_trap_i=1 while core_halt_o=0 SHALL set HIT.BP and latch core_pc_i into PPC.
REQ-026 core_retire_i=1 while core_halt_o=0 and CTRL.SSTE=1 SHALL set HIT.SS and latch core_pc_i into PPC.
REQ-027 If a trap and a step-retire occur in the same cycle, both HIT bits SHALL set; PPC SHALL take core_pc_i.
REQ-028 core_trap_i and core_retire_i SHALL be ignored while core_halt_o=1.
REQ-029 If a HIT set event and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-030 CYCLE SHALL increment by 1 in every cycle with core_halt_o=0 and wrap from 0xFFFFFFFF to 0; a CYCLE write in the same cycle SHALL win (result 0).
REQ-031 dbg_bp_o SHALL equal HIT.BP | HIT.SS.

Reset
REQ-032 While cpu_rst_i=1: the FSM SHALL be in IDLE; CTRL, HIT, PPC, CYCLE and core_npc_o SHALL be 0; dbg_ack_o, core_npc_we_o and dbg_bp_o SHALL be 0; core_halt_o SHALL equal dbg_stall_i.
REQ-033 Reset asserted mid-access SHALL abort the access with no ack and no register update; after reset release, a still-high dbg_stb_i SHALL be treated as a new access.

Verification
REQ-034 Write CTRL=0x1, then read CTRL -> ack 1 cycle after each strobe, dbg_data_o=0x00000001, core_halt_o=1, CYCLE frozen.
REQ-035 CTRL=0, trap pulse with core_pc_i=0x1C000080 -> next cycle HIT=0x1, PPC=0x1C000080, dbg_bp_o=1, core_halt_o=1; write HIT=0x1 -> dbg_bp_o=0, core_halt_o=0.
REQ-036 SSTE=1, retire pulse with pc=0x100 in the same cycle as a trap -> HIT=0x3, PPC=0x100; a second retire while halted -> no change.
REQ-037 Write NPC=0xDEADBEEF -> core_npc_we_o high for exactly 1 cycle after ack, core_npc_o=0xDEADBEEF held thereafter.
REQ-038 Preload CYCLE to 0xFFFFFFFF (force/backdoor), run 1 cycle -> 0; write CYCLE coincident with an increment -> 0.
REQ-039 Assert cpu_rst_i during the ACK state of a write to CTRL=0x1 -> no effect, CTRL=0; hold dbg_stb_i high across reset release -> one new ack 1 cycle after release.
